fetch_ifid: RTL
===============

# fetch_ifid

Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS pipeline. It holds the PC, drives a request/ready handshake to instruction memory, and selects the next PC from exception, ERET, branch, jump or sequential sources. It produces the 64-bit `ifid_reg` word consumed by the ID-stage decoder, with stall, flush and redirect-squash handling.

## Interface
- `RESET_PC`, default `32'h0000_3000`: PC loaded on reset.
- `EXC_VECTOR`, default `32'h0000_4180`: PC loaded on exception entry.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `stall`, in, 1: hazard unit hold; freezes PC and IF/ID.
- `flush`, in, 1: load a bubble into IF/ID.
- `jump_en`, in, 1: J/JAL/JR/JALR redirect from ID.
- `jump_target`, in, 32: target for `jump_en`.
- `branch_en`, in, 1: taken-branch redirect from EX.
- `branch_target`, in, 32: target for `branch_en`.
- `exc_en`, in, 1: exception/syscall entry.
- `eret_en`, in, 1: return from exception.
- `epc`, in, 32: return address for `eret_en`.
- `imem_req`, out, 1: fetch request.
- `imem_addr`, out, 32: fetch address; always equals `pc`.
- `imem_rdata`, in, 32: instruction word; valid when `imem_ready` is high.
- `imem_ready`, in, 1: memory completes the request this cycle.
- `pc`, out, 32: current fetch PC; bits [1:0] are always 0.
- `ifid_reg`, out, 64: bits [63:32] are PC+4 of the instruction, bits [31:0] are the instruction.
- `ifid_valid`, out, 1: `ifid_reg` holds a real instruction.

## Operation
- **Redirect priority:** `exc_en` > `eret_en` > `branch_en` > `jump_en` > sequential (PC+4).
  - Targets have bits [1:0] forced to 00.
  - PC+4 wraps modulo 2^32.
- **Fetch completion:** a fetch completes on a cycle with `imem_req & imem_ready & !stall`.
- **State RUN:**
  - Completion with no redirect: `pc` <= PC+4; IF/ID <= {PC+4, `imem_rdata`}; `ifid_valid` <= 1.
  - Redirect with `imem_ready` high, or with the request idle: `pc` <= target. The current fetch is squashed: IF/ID <= {32'h0, 32'h0} and `ifid_valid` <= 0, unless `stall` is high, in which case IF/ID holds.
  - Redirect while a request is outstanding (`imem_ready` low): `imem_addr` must stay stable. Latch the target into `pend_pc` and go to state DROP.
- **State DROP:**
  - `imem_req` stays high with the old address.
  - When `imem_ready` arrives, discard `imem_rdata`, set `pc` <= `pend_pc`, load a bubble into IF/ID (unless stalled), and return to RUN.
  - A higher-or-equal priority redirect arriving in DROP overwrites `pend_pc`.
- **Stall:** `pc` and IF/ID hold, and `imem_req` stays high on the same address. A redirect during stall still updates `pc` (or `pend_pc`).
- **Flush:** IF/ID <= bubble and `ifid_valid` <= 0. Flush overrides both stall and completion for IF/ID. Flush does not affect `pc`.
- **Bubble encoding:** `ifid_reg` = 64'h0, which decodes as SLL $0,$0,0 (NOP).

## Timing
- **Reset values (asynchronous):**
  - `pc` = `imem_addr` = `RESET_PC`
  - `imem_req` = 0
  - `ifid_reg` = 64'h0
  - `ifid_valid` = 0
  - state = RUN, `pend_pc` = 0
- `imem_req` is registered and rises on the first `clk` edge after `rst_n` deasserts; it then stays high.
- Reset asserted mid-fetch or in DROP returns all of the above at once; no pending redirect survives.
- **Throughput:** a zero-wait memory (`imem_ready` tied high) sustains 1 instruction per cycle. IF/ID updates on the edge that completes the fetch.
- **Redirect latency:** the redirect is sampled at edge N and `imem_addr` shows the target after edge N. In DROP, the target appears after the edge on which `imem_ready` is sampled high.
- `imem_addr` changes only on edges where a fetch completed, a redirect was taken without an outstanding wait, or DROP resolved.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset and sequential fetch:** release `rst_n` with `imem_ready`=1 and memory returning `32'h2008_0005` at 0x3000. Expect `imem_addr` 0x3000, 0x3004, 0x3008 on consecutive cycles, `ifid_reg`=`64'h0000_3004_2008_0005`, and `ifid_valid`=1.
- **Stall/flush:** hold `stall` for 3 cycles. Expect `pc` and `ifid_reg` frozen. Then assert `flush` and `stall` together: expect `ifid_reg`=0, `ifid_valid`=0, and `pc` unchanged.
- **Priority:** in one cycle assert `exc_en`, `branch_en` (0x3100) and `jump_en` (0x3200). Expect `pc`=0x4180 and IF/ID bubble. Repeat with only `branch_en`+`jump_en`: expect 0x3100.
- **Wait-state redirect:** with `imem_ready`=0 at 0x3008, assert `jump_en` to 0x3040. Expect `imem_addr` to stay at 0x3008 until ready, the returned data discarded (`ifid_valid`=0), and then `imem_addr`=0x3040.
- **ERET and alignment:** `eret_en` with `epc`=0x3007 gives `pc`=0x3004. Also check PC wrap: with `pc`=0xFFFF_FFFC, the next `pc` is 0x0000_0000 and `ifid_reg[63:32]`=0.
- **Reset mid-DROP:** assert `rst_n`=0 asynchronously while in DROP. Expect `pc`=0x3000 and `imem_req`=0 immediately, and no jump to the old `pend_pc` after release.

Source files
------------

// File: rtl/fetch_ifid_if.sv
// Instruction-memory fetch handshake between the IF stage and instruction memory.
//   imem_req   : fetch request (driven by fetch stage)
//   imem_addr  : fetch address (driven by fetch stage)
//   imem_rdata : instruction word, valid while imem_ready is high
//   imem_ready : memory completes the request this cycle
interface fetch_ifid_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );
endinterface

// File: rtl/fetch_ifid.sv
// Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS pipeline.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall, flush        : hazard hold of PC and IF/ID; bubble into IF/ID
//   jump_*, branch_*    : ID jump and EX taken-branch redirects
//   exc_en, eret_en/epc : exception entry, return from exception
//   imem                : fetch handshake (master side)
//   pc                  : current fetch PC (same register as imem_addr)
//   ifid_reg/ifid_valid : {PC+4, instruction} for the decoder and its valid flag
module fetch_ifid #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              jump_en,
   input  logic [31:0]       jump_target,
   input  logic              branch_en,
   input  logic [31:0]       branch_target,
   input  logic              exc_en,
   input  logic              eret_en,
   input  logic [31:0]       epc,
   fetch_ifid_if.master      imem,
   output logic [31:0]       pc,
   output logic [63:0]       ifid_reg,
   output logic              ifid_valid
);

   localparam int unsigned W_PC   = 32;
   localparam int unsigned W_IFID = 64;
   localparam int unsigned W_PRIO = 2;

   localparam logic [W_PC-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic {RUN, DROP} state_t;

   state_t              state_q, state_d;
   logic [W_PC-1:0]     pc_d;
   logic [W_PC-1:0]     pend_q, pend_d;
   logic [W_PRIO-1:0]   prio_q, prio_d;
   logic [W_IFID-1:0]   ifid_d;
   logic                valid_d;
   logic                req_q;

   logic                redir_c;
   logic [W_PC-1:0]     tgt_c;
   logic [W_PRIO-1:0]   rprio_c;
   logic [W_PC-1:0]     pc_inc_c;
   logic                squash_c;
   logic                load_c;
   logic                take_new_c;

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc;

   // Redirect source selection; priority level 3 (exc) down to 0 (jump)
   always_comb begin
      redir_c = 1'b1;
      tgt_c   = '0;
      rprio_c = '0;
      if (exc_en) begin
         tgt_c   = EXC_VECTOR & ALIGN_MASK;
         rprio_c = W_PRIO'(3);
      end else if (eret_en) begin
         tgt_c   = epc & ALIGN_MASK;
         rprio_c = W_PRIO'(2);
      end else if (branch_en) begin
         tgt_c   = branch_target & ALIGN_MASK;
         rprio_c = W_PRIO'(1);
      end else if (jump_en) begin
         tgt_c   = jump_target & ALIGN_MASK;
         rprio_c = W_PRIO'(0);
      end else begin
         redir_c = 1'b0;
      end
   end

   // Next-state and next-register values
   always_comb begin
      state_d    = state_q;
      pc_d       = pc;
      pend_d     = pend_q;
      prio_d     = prio_q;
      ifid_d     = ifid_reg;
      valid_d    = ifid_valid;
      squash_c   = 1'b0;
      load_c     = 1'b0;
      take_new_c = 1'b0;
      pc_inc_c   = pc + W_PC'(4);

      case (state_q)
         RUN: begin
            if (redir_c) begin
               if (imem.imem_ready || !req_q) begin
                  pc_d     = tgt_c;
                  squash_c = 1'b1;
               end else begin
                  // Outstanding request: keep the address stable, remember the target
                  pend_d  = tgt_c;
                  prio_d  = rprio_c;
                  state_d = DROP;
               end
            end else if (req_q && imem.imem_ready && !stall) begin
               pc_d   = pc_inc_c;
               load_c = 1'b1;
            end
         end
         DROP: begin
            take_new_c = redir_c && (rprio_c >= prio_q);
            if (take_new_c) begin
               pend_d = tgt_c;
               prio_d = rprio_c;
            end
            if (imem.imem_ready) begin
               // Returned word belongs to the abandoned path and is discarded
               pc_d     = take_new_c ? tgt_c : pend_q;
               squash_c = 1'b1;
               state_d  = RUN;
            end
         end
         default: state_d = RUN;
      endcase

      if (flush || (squash_c && !stall)) begin
         ifid_d  = '0;
         valid_d = 1'b0;
      end else if (load_c) begin
         ifid_d  = {pc_inc_c, imem.imem_rdata};
         valid_d = 1'b1;
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         pc         <= RESET_PC & ALIGN_MASK;
         pend_q     <= '0;
         prio_q     <= '0;
         ifid_reg   <= '0;
         ifid_valid <= 1'b0;
         req_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc         <= pc_d;
         pend_q     <= pend_d;
         prio_q     <= prio_d;
         ifid_reg   <= ifid_d;
         ifid_valid <= valid_d;
         req_q      <= 1'b1;
      end
   end

endmodule
